// File: rtl/flow_control_pkg.sv
// flow_control_pkg: shared definitions for the control word executor.
//   - control word field bit positions (55-bit word from the decoders)
//   - load_src encodings and executor state encoding
//   - decoded control word struct plus the subset latched for execution
//   - DATA_W default
package flow_control_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NUM_REGS   = 16;
    localparam int CW_W       = 55;

    // Field bit positions (LSB of multi-bit fields)
    localparam int CW_PC_INC       = 54;
    localparam int CW_ALU_OP_LSB   = 50;
    localparam int CW_A_ALT_LSB    = 34;
    localparam int CW_B_ALT_LSB    = 18;
    localparam int CW_A_SEL_LSB    = 14;
    localparam int CW_B_SEL_LSB    = 10;
    localparam int CW_A_SRC        = 9;
    localparam int CW_B_SRC        = 8;
    localparam int CW_OUT_SEL_LSB  = 4;
    localparam int CW_LOAD_SRC_LSB = 2;
    localparam int CW_STORE_MEM    = 1;
    localparam int CW_STORE_STK    = 0;

    typedef enum logic [1:0] {
        LD_ALU = 2'b00,
        LD_MEM = 2'b01,
        LD_NOP = 2'b10,
        LD_STK = 2'b11
    } load_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } exec_state_e;

    typedef struct packed {
        logic        pc_inc;
        logic [3:0]  alu_op;
        logic [15:0] a_altern;
        logic [15:0] b_altern;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic        a_src;
        logic        b_src;
        logic [3:0]  out_sel;
        logic [1:0]  load_src;
        logic        store_mem;
        logic        store_stk;
    } cw_t;

    // Fields still needed after the operands have been issued to the ALU
    typedef struct packed {
        logic        pc_inc;
        logic [3:0]  out_sel;
        logic [1:0]  load_src;
        logic        store_mem;
        logic        store_stk;
    } exec_t;

    function automatic cw_t decode_cw(input logic [CW_W-1:0] w);
        cw_t d;
        d.pc_inc    = w[CW_PC_INC];
        d.alu_op    = w[CW_ALU_OP_LSB +: 4];
        d.a_altern  = w[CW_A_ALT_LSB +: 16];
        d.b_altern  = w[CW_B_ALT_LSB +: 16];
        d.a_sel     = w[CW_A_SEL_LSB +: 4];
        d.b_sel     = w[CW_B_SEL_LSB +: 4];
        d.a_src     = w[CW_A_SRC];
        d.b_src     = w[CW_B_SRC];
        d.out_sel   = w[CW_OUT_SEL_LSB +: 4];
        d.load_src  = w[CW_LOAD_SRC_LSB +: 2];
        d.store_mem = w[CW_STORE_MEM];
        d.store_stk = w[CW_STORE_STK];
        return d;
    endfunction

endpackage

// File: rtl/cw_register_file.sv
// cw_register_file: 16 x DATA_W register file for the executor.
//   clock, reset_n        : clock, async active-low reset (clears all regs)
//   rd_a_*, rd_b_*        : two combinational read ports
//   wr_en/wr_addr/wr_data : single write port, written on the rising edge
//   dbg_sel/dbg_data      : combinational debug read port
module cw_register_file
    import flow_control_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [3:0]        rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [3:0]        rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-write value during the write cycle
    assign rd_a_data = regs[rd_a_addr];
    assign rd_b_data = regs[rd_b_addr];
    assign dbg_data  = regs[dbg_sel];

endmodule

// File: rtl/control_word_executor.sv
// control_word_executor: sequences one 55-bit control word per handshake
// through IDLE -> EXEC -> (MEM) -> WB -> IDLE.
//   clock, reset_n          : clock, async active-low reset
//   control_word, cw_valid  : input word and valid; cw_ready high in IDLE
//   alu_op, alu_a, alu_b    : operands to the external ALU, alu_result back
//   mem_*                   : memory/stack bus, mem_req held until mem_ack
//   pc_advance              : one-cycle pulse in WB when pc_inc is set
//   bus_error               : sticky bus timeout flag
//   dbg_sel, dbg_data       : debug register read
// Optional feature macro: CW_EXECUTOR_MEM_TIMEOUT_EN enables the MEM wait
// timeout (TIMEOUT_CYCLES); without it MEM waits forever and bus_error is 0.
module control_word_executor
    import flow_control_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CW_W-1:0]   control_word,
    input  logic              cw_valid,
    output logic              cw_ready,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_space,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              pc_advance,
    output logic              bus_error,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    exec_state_e       state;
    cw_t               cw_in;
    exec_t             cw_q;
    logic [3:0]        rd_a_addr;
    logic [DATA_W-1:0] rd_a_data, rd_b_data;
    logic [DATA_W-1:0] res_q, rdata_q;
    logic              is_store, to_mem, wr_en, wr_block;
    logic [DATA_W-1:0] wr_data;

    assign cw_in = decode_cw(control_word);

    always_comb begin
        // Port A serves operand A at accept time, then the store data in EXEC
        rd_a_addr = (state == ST_IDLE) ? cw_in.a_sel : cw_q.out_sel;
        is_store  = cw_q.store_mem | cw_q.store_stk;
        to_mem    = is_store | (cw_q.load_src == LD_MEM) | (cw_q.load_src == LD_STK);
        wr_en     = (state == ST_WB) && !is_store && (cw_q.load_src != LD_NOP) && !wr_block;
        wr_data   = (cw_q.load_src == LD_ALU) ? res_q : rdata_q;
    end

`ifdef CW_EXECUTOR_MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] mem_cnt;
    logic             timed_out;
    assign wr_block = timed_out;
`else
    assign wr_block  = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cw_q       <= '0;
            cw_ready   <= 1'b1;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_space  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pc_advance <= 1'b0;
            res_q      <= '0;
            rdata_q    <= '0;
`ifdef CW_EXECUTOR_MEM_TIMEOUT_EN
            mem_cnt    <= '0;
            timed_out  <= 1'b0;
            bus_error  <= 1'b0;
`endif
        end else begin
            pc_advance <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cw_valid) begin
                        cw_q     <= '{cw_in.pc_inc, cw_in.out_sel, cw_in.load_src,
                                      cw_in.store_mem, cw_in.store_stk};
                        alu_op   <= cw_in.alu_op;
                        alu_a    <= cw_in.a_src ? DATA_W'(cw_in.a_altern) : rd_a_data;
                        alu_b    <= cw_in.b_src ? DATA_W'(cw_in.b_altern) : rd_b_data;
                        cw_ready <= 1'b0;
                        state    <= ST_EXEC;
`ifdef CW_EXECUTOR_MEM_TIMEOUT_EN
                        timed_out <= 1'b0;
`endif
                    end
                end
                ST_EXEC: begin
                    res_q <= alu_result;
                    if (to_mem) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        // store_stk wins when both store bits are set
                        mem_space <= is_store ? cw_q.store_stk : (cw_q.load_src == LD_STK);
                        mem_addr  <= alu_result;
                        mem_wdata <= rd_a_data;
                        state     <= ST_MEM;
`ifdef CW_EXECUTOR_MEM_TIMEOUT_EN
                        mem_cnt   <= '0;
`endif
                    end else begin
                        pc_advance <= cw_q.pc_inc;
                        state      <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        rdata_q    <= mem_rdata;
                        mem_req    <= 1'b0;
                        pc_advance <= cw_q.pc_inc;
                        state      <= ST_WB;
                    end
`ifdef CW_EXECUTOR_MEM_TIMEOUT_EN
                    // Counter holds the number of completed MEM cycles minus one
                    else if (mem_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_req    <= 1'b0;
                        bus_error  <= 1'b1;
                        timed_out  <= 1'b1;
                        pc_advance <= cw_q.pc_inc;
                        state      <= ST_WB;
                    end else begin
                        mem_cnt <= mem_cnt + 1'b1;
                    end
`endif
                end
                ST_WB: begin
                    cw_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cw_register_file #(.DATA_W(DATA_W)) u_rf (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_a_addr (rd_a_addr),
        .rd_a_data (rd_a_data),
        .rd_b_addr (cw_in.b_sel),
        .rd_b_data (rd_b_data),
        .wr_en     (wr_en),
        .wr_addr   (cw_q.out_sel),
        .wr_data   (wr_data),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

endmodule

// File: tb/tb_control_word_executor.sv
// Testbench for control_word_executor: table of register-only words plus
// hand-written bus, back-to-back, reset and (when compiled in) timeout cases.
module tb_control_word_executor;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [54:0] control_word;
    logic        cw_valid;
    logic        cw_ready;
    logic [3:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        mem_req, mem_we, mem_space;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        pc_advance, bus_error;
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_data;

    always #5 clock = ~clock;

    // External ALU model
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = alu_a;
            default: alu_result = 16'h0000;
        endcase
    end

    control_word_executor #(.DATA_W(16), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset_n(reset_n), .control_word(control_word),
        .cw_valid(cw_valid), .cw_ready(cw_ready), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_space(mem_space),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc_advance(pc_advance), .bus_error(bus_error),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [54:0] mk(input logic pc, input logic [3:0] op,
                                       input logic [15:0] aa, input logic [15:0] ba,
                                       input logic [3:0] as, input logic [3:0] bs,
                                       input logic asrc, input logic bsrc,
                                       input logic [3:0] os, input logic [1:0] ls,
                                       input logic sm, input logic ss);
        return {pc, op, aa, ba, as, bs, asrc, bsrc, os, ls, sm, ss};
    endfunction

    typedef struct {
        int          lat;     // edges after accept until cw_ready seen again
        int          memcyc;  // cycles with mem_req high
        int          pcp;     // pc_advance pulses
        int          pc_cyc;  // cycle index of the pc_advance pulse
        logic [15:0] wb_dbg;  // dbg_data during the WB cycle
        logic        we, sp, stable;
        logic [15:0] addr, wdata;
    } res_t;

    // Called #1 after an edge with the DUT idle. ack_at = MEM cycle (1-based)
    // in which mem_ack is driven; 0 = never.
    task automatic run_word(input logic [54:0] cw, input int ack_at,
                            input logic [15:0] rdata, output res_t r);
        r = '{0, 0, 0, 0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0};
        control_word = cw;
        cw_valid = 1'b1;
        @(posedge clock); #1;
        cw_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (cw_ready) begin
                r.lat = c;
                break;
            end
            if (pc_advance) begin
                r.pcp++;
                r.pc_cyc = c;
                r.wb_dbg = dbg_data;
            end
            if (mem_req) begin
                r.memcyc++;
                if (r.memcyc == 1) begin
                    r.we = mem_we; r.sp = mem_space; r.addr = mem_addr; r.wdata = mem_wdata;
                end else if ({mem_we, mem_space, mem_addr, mem_wdata} !== {r.we, r.sp, r.addr, r.wdata}) begin
                    r.stable = 1'b0;
                end
                mem_ack   = (r.memcyc == ack_at);
                mem_rdata = rdata;
            end else begin
                mem_ack = 1'b0;
            end
            @(posedge clock); #1;
        end
        mem_ack = 1'b0;
        if (r.lat == 0) chk("word_completes", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [54:0] cw;
        logic [3:0]  osel;
        logic [15:0] exp;
        logic        exp_pc;
    } vec_t;

    vec_t        tv[7];
    logic [15:0] shadow[16];
    res_t        r;

    initial begin
        tv[0] = '{mk(1, 0, 16'h0003, 16'h0004, 0, 0, 1, 1, 5, 2'b00, 0, 0), 4'd5, 16'h0007, 1'b1};
        tv[1] = '{mk(1, 1, 16'h0010, 16'h0001, 0, 0, 1, 1, 1, 2'b00, 0, 0), 4'd1, 16'h000F, 1'b1};
        tv[2] = '{mk(1, 2, 16'h0000, 16'h0003, 5, 0, 0, 1, 2, 2'b00, 0, 0), 4'd2, 16'h0003, 1'b1};
        tv[3] = '{mk(1, 4, 16'h0000, 16'h0000, 1, 5, 0, 0, 3, 2'b00, 0, 0), 4'd3, 16'h0008, 1'b1};
        tv[4] = '{mk(1, 0, 16'h0100, 16'h0000, 0, 0, 1, 1, 1, 2'b10, 0, 0), 4'd1, 16'h000F, 1'b1};
        tv[5] = '{mk(1, 5, 16'h00AA, 16'h0000, 0, 0, 1, 1, 5, 2'b00, 0, 0), 4'd5, 16'h00AA, 1'b1};
        tv[6] = '{mk(0, 3, 16'h0000, 16'h0000, 2, 3, 0, 0, 4, 2'b00, 0, 0), 4'd4, 16'h000B, 1'b0};
        for (int i = 0; i < 16; i++) shadow[i] = 16'h0;

        reset_n = 1'b0; control_word = '0; cw_valid = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0; dbg_sel = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ctrl", {cw_ready, mem_req, mem_we, mem_space, pc_advance, bus_error}, 6'b100000);
        chk("reset_bus", {mem_addr, mem_wdata}, 32'h0);
        chk("reset_alu", {alu_op, alu_a}, 20'h0);
        chk("reset_alu_b", alu_b, 16'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Register-only words
        for (int i = 0; i < 7; i++) begin
            dbg_sel = tv[i].osel;
            run_word(tv[i].cw, 0, 16'h0, r);
            chk($sformatf("v%0d_lat", i), r.lat, 3);
            chk($sformatf("v%0d_pcp", i), r.pcp, tv[i].exp_pc ? 1 : 0);
            if (tv[i].exp_pc) begin
                chk($sformatf("v%0d_pc_cyc", i), r.pc_cyc, 2);
                chk($sformatf("v%0d_wb_old", i), r.wb_dbg, shadow[tv[i].osel]);
            end
            chk($sformatf("v%0d_memcyc", i), r.memcyc, 0);
            chk($sformatf("v%0d_reg", i), dbg_data, tv[i].exp);
            shadow[tv[i].osel] = tv[i].exp;
        end
        chk("alu_hold", {alu_op, alu_a, alu_b}, {4'd3, 16'h0003, 16'h0008});

        // Stray ack in IDLE has no effect
        mem_ack = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("stray_ack", {mem_req, cw_ready, pc_advance}, 3'b010);
        mem_ack = 1'b0;

        // Store to memory, ack in 3rd MEM cycle; load_src=00 must be ignored
        dbg_sel = 4'd5;
        run_word(mk(1, 5, 16'h0010, 16'h0, 0, 0, 1, 1, 5, 2'b00, 1, 0), 3, 16'h0, r);
        chk("st_memcyc", r.memcyc, 3);
        chk("st_bus", {r.we, r.sp, r.addr, r.wdata}, {1'b1, 1'b0, 16'h0010, 16'h00AA});
        chk("st_stable", r.stable, 1'b1);
        chk("st_lat", r.lat, 6);
        chk("st_pc", {r.pcp[3:0], r.pc_cyc[3:0]}, {4'd1, 4'd5});
        chk("st_noreg", dbg_data, 16'h00AA);

        // Both store bits: stack wins
        run_word(mk(1, 5, 16'h0030, 16'h0, 0, 0, 1, 1, 2, 2'b00, 1, 1), 1, 16'h0, r);
        chk("st2_bus", {r.we, r.sp, r.addr, r.wdata}, {1'b1, 1'b1, 16'h0030, 16'h0003});

        // Stack load, ack in first MEM cycle
        dbg_sel = 4'd8;
        run_word(mk(1, 5, 16'h0020, 16'h0, 0, 0, 1, 1, 8, 2'b11, 0, 0), 1, 16'hBEEF, r);
        chk("ldk_bus", {r.we, r.sp, r.addr}, {1'b0, 1'b1, 16'h0020});
        chk("ldk_timing", {r.memcyc[3:0], r.pc_cyc[3:0], r.lat[3:0]}, {4'd1, 4'd3, 4'd4});
        chk("ldk_wb_old", r.wb_dbg, 16'h0000);
        chk("ldk_reg", dbg_data, 16'hBEEF);

        // Memory load, ack in second MEM cycle
        dbg_sel = 4'd9;
        run_word(mk(1, 5, 16'h0044, 16'h0, 0, 0, 1, 1, 9, 2'b01, 0, 0), 2, 16'h1234, r);
        chk("ldm_bus", {r.we, r.sp, r.addr, r.memcyc[3:0]}, {1'b0, 1'b0, 16'h0044, 4'd2});
        chk("ldm_reg", dbg_data, 16'h1234);

        // Back-to-back: second word depends on first's result
        control_word = mk(1, 5, 16'h0011, 16'h0, 0, 0, 1, 1, 6, 2'b00, 0, 0);
        cw_valid = 1'b1;
        @(posedge clock); #1;
        control_word = mk(1, 0, 16'h0, 16'h0001, 6, 0, 0, 1, 7, 2'b00, 0, 0);
        chk("b2b_exec", cw_ready, 1'b0);
        @(posedge clock); #1;
        chk("b2b_wb", {cw_ready, pc_advance}, 2'b01);
        @(posedge clock); #1;
        chk("b2b_idle", {cw_ready, pc_advance}, 2'b10);
        @(posedge clock); #1;
        chk("b2b_second", cw_ready, 1'b0);
        cw_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("b2b_done", cw_ready, 1'b1);
        dbg_sel = 4'd6; #1;
        chk("b2b_r6", dbg_data, 16'h0011);
        dbg_sel = 4'd7; #1;
        chk("b2b_r7", dbg_data, 16'h0012);

        // Reset during MEM
        @(posedge clock); #1;
        control_word = mk(1, 5, 16'h0050, 16'h0, 0, 0, 1, 1, 5, 2'b00, 1, 0);
        cw_valid = 1'b1;
        @(posedge clock); #1;
        cw_valid = 1'b0;
        @(posedge clock); #1;
        chk("rst_in_mem", mem_req, 1'b1);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", {mem_req, cw_ready, pc_advance}, 3'b010);
        dbg_sel = 4'd5; #1;
        chk("rst_r5", dbg_data, 16'h0000);
        @(posedge clock); #3;
        reset_n = 1'b1;
        begin
            int pcs = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clock); #1;
                if (pc_advance || mem_req) pcs++;
            end
            chk("rst_quiet", pcs, 0);
        end
        dbg_sel = 4'd8; #1;
        chk("rst_r8", dbg_data, 16'h0000);

`ifdef CW_EXECUTOR_MEM_TIMEOUT_EN
        // Timeout with no ack: 4 MEM cycles, no writeback, sticky error
        dbg_sel = 4'd9;
        run_word(mk(1, 5, 16'h0060, 16'h0, 0, 0, 1, 1, 9, 2'b01, 0, 0), 0, 16'h5555, r);
        chk("to_memcyc", r.memcyc, 4);
        chk("to_lat_pc", {r.lat[3:0], r.pcp[3:0]}, {4'd7, 4'd1});
        chk("to_err", bus_error, 1'b1);
        chk("to_noreg", dbg_data, 16'h0000);
        dbg_sel = 4'd10;
        run_word(mk(1, 5, 16'h0005, 16'h0, 0, 0, 1, 1, 10, 2'b00, 0, 0), 0, 16'h0, r);
        chk("to_next", {r.lat[3:0], dbg_data}, {4'd3, 16'h0005});
        chk("to_sticky", bus_error, 1'b1);
        // Ack on the limit cycle wins
        dbg_sel = 4'd11;
        run_word(mk(1, 5, 16'h0070, 16'h0, 0, 0, 1, 1, 11, 2'b01, 0, 0), 4, 16'h7777, r);
        chk("to_ack_wins", {r.memcyc[3:0], dbg_data}, {4'd4, 16'h7777});
`else
        chk("no_bus_error", bus_error, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
